// File: rtl/vm_pkg.sv
// Shared types for the VMCS table: command opcodes, lifecycle states and error codes.
package vm_pkg;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_VMXON  = 3'd1,
      OP_VMXOFF = 3'd2,
      OP_PTRLD  = 3'd3,
      OP_CLEAR  = 3'd4,
      OP_LAUNCH = 3'd5,
      OP_RESUME = 3'd6,
      OP_EXIT   = 3'd7
   } vm_op_e;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_ROOT  = 2'd1,
      ST_ENTRY = 2'd2,
      ST_GUEST = 2'd3
   } vmcs_state_e;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_BAD_STATE = 2'd1,
      ERR_BAD_SLOT  = 2'd2,
      ERR_BAD_PTR   = 2'd3
   } vm_err_e;

   localparam int unsigned VMID_HOST = 0;

endpackage

// File: rtl/vmcs_table_if.sv
// Command port between the privileged-instruction decoder and the VMCS table.
interface vmcs_table_if
   import vm_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int VMID_W    = 8,
   parameter int REASON_W  = 6
);
   localparam int SLOT_W = $clog2(NUM_SLOTS);

   logic                cmd_valid_i;
   logic                cmd_ready_o;
   vm_op_e              cmd_op_i;
   logic [SLOT_W:0]     cmd_slot_i;
   logic [VMID_W-1:0]   cmd_vmid_i;
   logic [REASON_W-1:0] exit_reason_i;
   logic                done_o;
   logic                err_o;
   vm_err_e             err_code_o;

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_slot_i, cmd_vmid_i, exit_reason_i,
      input  cmd_ready_o, done_o, err_o, err_code_o
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_slot_i, cmd_vmid_i, exit_reason_i,
      output cmd_ready_o, done_o, err_o, err_code_o
   );

endinterface

// File: rtl/vmcs_slot_array.sv
// Per-slot valid/VMID/launched storage: one write port, two combinational read ports.
module vmcs_slot_array #(
   parameter int NUM_SLOTS = 4,
   parameter int VMID_W    = 8,
   localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [SLOT_W-1:0] wr_idx,
   input  logic [VMID_W-1:0] wr_vmid,
   input  logic              wr_launched,
   input  logic [SLOT_W-1:0] cur_idx,
   output logic              cur_valid,
   output logic [VMID_W-1:0] cur_vmid,
   output logic              cur_launched,
   input  logic [SLOT_W-1:0] cmd_idx,
   output logic              cmd_valid
);

   logic [NUM_SLOTS-1:0] valid_q;
   logic [NUM_SLOTS-1:0] launched_q;
   logic [VMID_W-1:0]    vmid_q [NUM_SLOTS];

   // NOTE: the array is small and must read as empty after reset, so every entry is reset
   // explicitly; a large RAM would instead rely on the valid bits alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= '0;
         launched_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) vmid_q[i] <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx]    <= 1'b1;
         launched_q[wr_idx] <= wr_launched;
         vmid_q[wr_idx]     <= wr_vmid;
      end
   end

   assign cur_valid    = valid_q[cur_idx];
   assign cur_vmid     = vmid_q[cur_idx];
   assign cur_launched = launched_q[cur_idx];
   assign cmd_valid    = valid_q[cmd_idx];

endmodule

// File: rtl/vmcs_table.sv
// Multi-slot VMCS table: sequences the VMX lifecycle and publishes the running guest's VMID.
module vmcs_table
   import vm_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int VMID_W    = 8,
   parameter int REASON_W  = 6,
   parameter int CNT_W     = 16,
   localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
   input  logic                clk,
   input  logic                rst_n,
   vmcs_table_if.slave         cmd,
   output logic                vmx_on_o,
   output logic                running_o,
   output logic [VMID_W-1:0]   current_vmid_o,
   output logic [SLOT_W-1:0]   cur_slot_o,
   output logic                cur_valid_o,
   output logic [REASON_W-1:0] exit_reason_o,
   output logic [CNT_W-1:0]    exit_count_o
);

   vmcs_state_e         state_q, state_d;
   logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
   logic                cur_valid_q, cur_valid_d;
   logic [REASON_W-1:0] reason_q, reason_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                done_q, done_d;
   vm_err_e             code_q, code_d;

   logic                wr_en, wr_launched;
   logic [SLOT_W-1:0]   wr_idx;
   logic [VMID_W-1:0]   wr_vmid;
   logic                slot_cur_valid, slot_cur_launched, slot_cmd_valid;
   logic [VMID_W-1:0]   slot_cur_vmid;

   logic                ready, accept, slot_oob;
   logic [SLOT_W-1:0]   cmd_idx;

   assign ready    = (state_q != ST_ENTRY);
   assign accept   = cmd.cmd_valid_i && ready;
   // Slot counts are powers of two, so the extra index bit alone flags out-of-range.
   assign slot_oob = cmd.cmd_slot_i[SLOT_W];
   assign cmd_idx  = cmd.cmd_slot_i[SLOT_W-1:0];

   vmcs_slot_array #(.NUM_SLOTS(NUM_SLOTS), .VMID_W(VMID_W)) u_slots (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_idx       (wr_idx),
      .wr_vmid      (wr_vmid),
      .wr_launched  (wr_launched),
      .cur_idx      (cur_slot_q),
      .cur_valid    (slot_cur_valid),
      .cur_vmid     (slot_cur_vmid),
      .cur_launched (slot_cur_launched),
      .cmd_idx      (cmd_idx),
      .cmd_valid    (slot_cmd_valid)
   );

   // NOTE: every signal gets its default before the case so no path leaves one unassigned
   // (which would infer a latch); combinational logic uses blocking '=' throughout.
   always_comb begin
      state_d     = state_q;
      cur_slot_d  = cur_slot_q;
      cur_valid_d = cur_valid_q;
      reason_d    = reason_q;
      count_d     = count_q;
      done_d      = 1'b0;
      code_d      = ERR_NONE;
      wr_en       = 1'b0;
      wr_idx      = cmd_idx;
      wr_vmid     = cmd.cmd_vmid_i;
      wr_launched = 1'b0;

      if (state_q == ST_ENTRY) begin
         state_d     = ST_GUEST;
         done_d      = 1'b1;
         wr_en       = 1'b1;
         wr_idx      = cur_slot_q;
         wr_vmid     = slot_cur_vmid;
         wr_launched = 1'b1;
      end else if (accept && cmd.cmd_op_i != OP_NOP) begin
         done_d = 1'b1;
         unique case (cmd.cmd_op_i)
            OP_VMXON: begin
               if (state_q != ST_OFF) code_d = ERR_BAD_STATE;
               else                   state_d = ST_ROOT;
            end
            OP_VMXOFF: begin
               if (state_q != ST_ROOT) code_d = ERR_BAD_STATE;
               else begin
                  state_d     = ST_OFF;
                  cur_valid_d = 1'b0;
               end
            end
            OP_PTRLD: begin
               if (state_q != ST_ROOT) code_d = ERR_BAD_STATE;
               else if (slot_oob)      code_d = ERR_BAD_SLOT;
               else if (!slot_cmd_valid) code_d = ERR_BAD_PTR;
               else begin
                  cur_slot_d  = cmd_idx;
                  cur_valid_d = 1'b1;
               end
            end
            OP_CLEAR: begin
               if (state_q != ST_ROOT) code_d = ERR_BAD_STATE;
               else if (slot_oob)      code_d = ERR_BAD_SLOT;
               else if (cmd.cmd_vmid_i == VMID_W'(VMID_HOST)) code_d = ERR_BAD_PTR;
               else begin
                  wr_en = 1'b1;
                  if (cmd_idx == cur_slot_q) cur_valid_d = 1'b0;
               end
            end
            OP_LAUNCH, OP_RESUME: begin
               if (state_q != ST_ROOT) code_d = ERR_BAD_STATE;
               else if (!cur_valid_q || !slot_cur_valid ||
                        (slot_cur_launched != (cmd.cmd_op_i == OP_RESUME)))
                  code_d = ERR_BAD_PTR;
               else begin
                  // Completion is reported when the entry finishes, not at acceptance.
                  state_d = ST_ENTRY;
                  done_d  = 1'b0;
               end
            end
            OP_EXIT: begin
               if (state_q != ST_GUEST) code_d = ERR_BAD_STATE;
               else begin
                  state_d  = ST_ROOT;
                  reason_d = cmd.exit_reason_i;
                  if (count_q != '1) count_d = count_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_OFF;
         cur_slot_q  <= '0;
         cur_valid_q <= 1'b0;
         reason_q    <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         code_q      <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         cur_slot_q  <= cur_slot_d;
         cur_valid_q <= cur_valid_d;
         reason_q    <= reason_d;
         count_q     <= count_d;
         done_q      <= done_d;
         code_q      <= code_d;
      end
   end

   assign cmd.cmd_ready_o = ready;
   assign cmd.done_o      = done_q;
   assign cmd.err_o       = done_q && (code_q != ERR_NONE);
   assign cmd.err_code_o  = code_q;

   assign vmx_on_o       = (state_q != ST_OFF);
   assign running_o      = (state_q == ST_GUEST);
   assign current_vmid_o = running_o ? slot_cur_vmid : VMID_W'(VMID_HOST);
   assign cur_slot_o     = cur_slot_q;
   assign cur_valid_o    = cur_valid_q;
   assign exit_reason_o  = reason_q;
   assign exit_count_o   = count_q;

endmodule
